// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding,
// parity-mode constants and the bit-vote helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    function automatic logic majority3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with a write-enable side and valid/ready read side.
// A write while full is ignored; the head is shown combinationally (zero when empty).
module uart_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    input  logic             rd_ready
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_wr;
    logic             do_rd;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign rd_valid = (wr_ptr != rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_wr    = wr_en && !full;
    assign do_rd    = rd_valid && rd_ready;
    assign rd_data  = rd_valid ? mem[rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with majority-vote bit decisions, optional parity,
// 1 or 2 stop bits and a receive FIFO carrying per-frame error flags.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_en,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_perr,
    output logic                 m_ferr,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 overrun,
    input  logic                 err_clr,
    output logic                 rx_busy,
    output logic [2:0]           fsm_state
);

    localparam int DIV_RAW = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W    = $clog2(OVERSAMPLE);
    localparam int FIFO_W  = DATA_BITS + 2;

    localparam logic [OS_W-1:0]  SMP_LO    = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  SMP_MID   = OS_W'(OVERSAMPLE / 2);
    localparam logic [OS_W-1:0]  SMP_HI    = OS_W'(OVERSAMPLE / 2 + 1);
    localparam logic [OS_W-1:0]  SMP_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);

    rx_state_t            state;
    rx_state_t            next_state;
    logic                 rx_meta;
    logic                 rx_sync;
    logic [DIV_W-1:0]     div_cnt;
    logic [OS_W-1:0]      os_cnt;
    logic [3:0]           bit_cnt;
    logic [2:0]           smp;
    logic [DATA_BITS-1:0] shift;
    logic                 perr_q;
    logic                 ferr_q;
    logic                 tick;
    logic                 bit_end;
    logic                 vote;
    logic                 par_exp;
    logic                 frame_ferr;
    logic                 push;
    logic                 fifo_full;
    logic [FIFO_W-1:0]    fifo_head;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    assign tick       = (state != ST_IDLE) && (div_cnt == DIV_LAST);
    assign bit_end    = tick && (os_cnt == SMP_LAST);
    assign vote       = majority3(smp);
    assign par_exp    = (^shift) ^ (PARITY == PAR_ODD);
    assign frame_ferr = ferr_q | ~vote;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        push       = 1'b0;
        unique case (state)
            ST_IDLE:   if (!rx_sync && rx_en) next_state = ST_START;
            ST_START:  if (bit_end) next_state = vote ? ST_IDLE : ST_DATA;
            ST_DATA: begin
                if (bit_end && bit_cnt == LAST_DATA)
                    next_state = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
            end
            ST_PARITY: if (bit_end) next_state = ST_STOP;
            ST_STOP: begin
                if (bit_end && bit_cnt == LAST_STOP) begin
                    next_state = ST_IDLE;
                    push       = 1'b1;
                end
            end
            default:   next_state = ST_IDLE;
        endcase
    end

    // Bit timing restarts from zero each time a start edge is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            os_cnt  <= '0;
            smp     <= '1;
        end else if (state == ST_IDLE) begin
            div_cnt <= '0;
            os_cnt  <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            if (tick) begin
                os_cnt <= os_cnt + OS_W'(1);
                if (os_cnt == SMP_LO)  smp[0] <= rx_sync;
                if (os_cnt == SMP_MID) smp[1] <= rx_sync;
                if (os_cnt == SMP_HI)  smp[2] <= rx_sync;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= '0;
            shift   <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else if (state == ST_IDLE) begin
            bit_cnt <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else if (bit_end) begin
            case (state)
                ST_DATA: begin
                    shift   <= {vote, shift[DATA_BITS-1:1]};
                    bit_cnt <= (bit_cnt == LAST_DATA) ? 4'd0 : bit_cnt + 4'd1;
                end
                ST_PARITY: perr_q <= (vote != par_exp);
                ST_STOP: begin
                    ferr_q  <= frame_ferr;
                    bit_cnt <= (bit_cnt == LAST_STOP) ? 4'd0 : bit_cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

    // A frame finishing into a full FIFO is lost; setting wins over clearing.
    always_ff @(posedge clk) begin
        if (rst)                    overrun <= 1'b0;
        else if (push && fifo_full) overrun <= 1'b1;
        else if (err_clr)           overrun <= 1'b0;
    end

    uart_sync_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (push),
        .wr_data  ({shift, perr_q, frame_ferr}),
        .full     (fifo_full),
        .rd_data  (fifo_head),
        .rd_valid (m_valid),
        .rd_ready (m_ready)
    );

    assign m_data    = fifo_head[FIFO_W-1:2];
    assign m_perr    = fifo_head[1];
    assign m_ferr    = fifo_head[0];
    assign rx_busy   = (state != ST_IDLE);
    assign fsm_state = state;

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, meaning line bit rate.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, meaning ticks per bit; legal values are 8 or 16.
REQ-004 SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame; legal range is 5..9.
REQ-005 SHALL have parameter PARITY, default 0, meaning parity mode: 0 = none, 1 = odd, 2 = even.
REQ-006 SHALL have parameter STOP_BITS, default 1, meaning number of stop bits checked; legal values are 1 or 2.
REQ-007 SHALL have parameter FIFO_DEPTH, default 4, meaning receive FIFO entries; must be a power of 2 and at least 2.
REQ-008 SHALL have port clk, input, 1 bit: clock; all logic on the rising edge.
REQ-009 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-010 SHALL have port rx_en, input, 1 bit: enables start-bit detection.
REQ-011 SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-012 SHALL have port m_data, output, DATA_BITS wide: received payload, LSB first on the line.
REQ-013 SHALL have port m_perr, output, 1 bit: parity error for the frame at the FIFO head.
REQ-014 SHALL have port m_ferr, output, 1 bit: framing error (bad stop bit) for the frame at the FIFO head.
REQ-015 SHALL have port m_valid, output, 1 bit: FIFO non-empty.
REQ-016 SHALL have port m_ready, input, 1 bit: consumer accepts the head entry when m_valid && m_ready.
REQ-017 SHALL have port overrun, output, 1 bit: sticky flag, set when a frame is dropped.
REQ-018 SHALL have port err_clr, input, 1 bit: a single-cycle pulse clears overrun.
REQ-019 SHALL have port rx_busy, output, 1 bit: high while the FSM is not in IDLE.

Function
REQ-020 SHALL pass rx through a 2-flop synchroniser, reset to 1, before any use.
REQ-021 SHALL generate a tick every DIV = CLK_HZ/(BAUD*OVERSAMPLE) clocks (integer division); the tick counter runs only while not in IDLE and restarts at 0 on leaving IDLE.
REQ-022 SHALL decide each bit by 2-of-3 majority vote of samples OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 within the bit.
REQ-023 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, in that order; the PARITY state is skipped when PARITY==0.
REQ-024 SHALL go from IDLE to START on the first clock with synced rx==0 and rx_en==1.
REQ-025 SHALL return from START to IDLE with nothing written and no flags when the voted start bit is 1 (glitch rejection).
REQ-026 SHALL shift DATA_BITS voted bits LSB first in DATA.
REQ-027 SHALL compute parity as the XOR of the payload, xor 1 for odd mode, and set perr on mismatch in PARITY.
REQ-028 SHALL check STOP_BITS voted stop bits in STOP and set ferr if any is 0.
REQ-029 SHALL, at the end of the last stop bit, write {data, perr, ferr} to the FIFO in one clock and return to IDLE in the same clock.
REQ-030 SHALL, if the FIFO is full at write time, drop the frame and set overrun; a simultaneous pop does not free space for that write.
REQ-031 SHALL, when push and pop occur in the same cycle with the FIFO non-full, perform both and leave the count unchanged.
REQ-032 SHALL give overrun set priority over err_clr in the same cycle.
REQ-033 SHALL present m_data/m_perr/m_ferr combinationally from the FIFO head, held stable while m_valid && !m_ready.
REQ-034 SHALL, when rx_en deasserts mid-frame, still complete that frame; rx_en gates only the IDLE to START transition.
REQ-035 SHALL give a first-byte latency of 1 clock from the end of the stop bit to m_valid high.

Reset
REQ-036 SHALL, while rst is high, set state IDLE, all counters 0, FIFO empty, m_valid=0, overrun=0, rx_busy=0, synchroniser=1, m_data/m_perr/m_ferr=0.
REQ-037 SHALL abort a frame in progress on rst and store nothing from it.

Structure
REQ-038 SHALL take the state typedef and the parity-mode constants PAR_NONE, PAR_ODD and PAR_EVEN from shared package uart_pkg.
REQ-039 SHALL put the FIFO in sub-module uart_sync_fifo, with WIDTH and DEPTH parameters and valid/ready on the read side.

Verification
REQ-040 SHALL cover defaults, frame 0x55 at 9600 baud -> m_data=0x55, perr=0, ferr=0, m_valid about 10 bit times (104167 clocks) after the start edge.
REQ-041 SHALL cover PARITY=2, DATA_BITS=7, frame 0x41 sent with parity bit 1 (should be 0) -> m_data=0x41, m_perr=1.
REQ-042 SHALL cover frame 0xA3 with stop bit 0 -> m_ferr=1, m_data=0xA3, next frame 0x3C received clean.
REQ-043 SHALL cover a 2000-clock low pulse on rx (less than half a bit) -> return to IDLE, m_valid stays 0.
REQ-044 SHALL cover five frames 0x01..0x05 with m_ready=0 and FIFO_DEPTH=4 -> overrun=1, pops yield 0x01..0x04, err_clr clears overrun.
REQ-045 SHALL cover rst asserted mid-DATA of 0x77, then frame 0x12 -> only 0x12 emerges.
